stage_id_mt: RTL and testbench
==============================

Name: stage_id_mt

Overview:
Parametrised decode/issue stage for the fine-grained multithreaded pipeline. It sits between the IF/ID and ID/EX boundaries.
- Holds one decoded instruction per cycle.
- Reads operands from the per-thread register file.
- Tracks outstanding writes per thread in a scoreboard, with same-cycle writeback bypass.
- Issues into EX through a valid/ready handshake, with per-thread flush and a stall-cycle counter.
Replaces the fixed-width ID stage: generalises thread count, register count and control-bundle width, and adds backpressure and RAW interlocking.

Parameters:
N_THREADS, 4, hardware thread count; TID_W = max(1, clog2(N_THREADS)).
XLEN, 32, data word width.
N_REGS, 32, architectural registers per thread; RID_W = clog2(N_REGS); register 0 is hardwired zero.
CTRL_W, 48, opaque decoded-control bundle width (alu func, mux selects, mem/branch flags), passed through untouched.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IF/ID holds a decoded instruction
in_ready  out  1  stage accepts the instruction this cycle
in_thread  in  TID_W  thread of the incoming instruction
in_pc  in  XLEN  instruction PC
in_exc  in  1  fetch exception (itlb/icache fault); operands ignored
in_src1, in_src2  in  RID_W each  source register ids
in_use1, in_use2  in  1 each  source actually read
in_dst  in  RID_W  destination id
in_wr  in  1  instruction writes in_dst
in_imm  in  XLEN  immediate
in_ctrl  in  CTRL_W  decoded control bundle
rf_rd1_idx, rf_rd2_idx  out  RID_W each  regfile read index (combinational = in_src1/2)
rf_rd_thread  out  TID_W  regfile read thread (= in_thread)
rf_rd1_data, rf_rd2_data  in  XLEN each  regfile read data, combinational
wb_valid  in  1  writeback/retire event clears scoreboard entry
wb_we  in  1  wb_data is architecturally valid (0 = killed instruction)
wb_thread  in  TID_W  writeback thread
wb_dst  in  RID_W  writeback register
wb_data  in  XLEN  writeback data
flush_valid  in  1  kill younger instructions of flush_thread
flush_thread  in  TID_W  thread being flushed
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_thread, out_pc, out_exc, out_dst, out_wr, out_imm, out_ctrl  out  as inputs  registered copies
out_op1, out_op2  out  XLEN each  registered operands
stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset: out_valid=0 and all out_* data=0; scoreboard all clear; stall_cnt=0. Reset mid-operation discards the held instruction.
- Scoreboard: busy[t][r], N_THREADS×N_REGS bits.
  - Set on issue when in_wr=1, in_exc=0, in_dst≠0.
  - Cleared when wb_valid at (wb_thread, wb_dst).
  - busy[t][0] is never set.
- Effective busy for the hazard check = busy minus the same-cycle wb clear. Set and clear of the same entry in one cycle: set wins.
- hazard = in_valid & !in_exc & ((in_use1 & ebusy[in_thread][in_src1]) | (in_use2 & ebusy[in_thread][in_src2])) with src≠0.
- issue_ok = !out_valid | out_ready.
- in_ready = issue_ok & !hazard & !(flush_valid & flush_thread==in_thread).
- Accept (in_valid & in_ready): output register loads next edge. Latency 1 cycle.
- Operand select, per source: 0 if src=0; else wb_data if wb_valid & wb_we & wb_thread==in_thread & wb_dst==src; else rf data.
- No accept & out_ready: out_valid←0. No accept & !out_ready: hold all outputs stable.
- Flush: if flush_valid & out_valid & out_thread==flush_thread, out_valid←0 next edge.
  - The flushed entry's busy bit stays set; downstream issues wb_valid with wb_we=0 for it.
  - Instructions of other threads are unaffected.
- Exceptions: in_exc instructions bypass the hazard check, do not set busy, and issue with out_exc=1.
- stall_cnt saturates at all-ones.

Test Plan:
1. Reset, then in_valid thread 0, src1=3 (rf=0x11), src2=4 (rf=0x22), dst=5, out_ready=1 -> next cycle out_valid=1, op1=0x11, op2=0x22; busy[0][5]=1.
2. Thread 0 writes r5, then thread 0 reads r5 with no wb -> in_ready=0 and stall_cnt increments every cycle; wb_valid=1, wb_we=1, thread 0, dst 5, data 0xABCD -> same-cycle accept with op1=0xABCD.
3. busy[0][5] set; thread 1 reads r5 -> issues immediately (per-thread isolation).
4. out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> new instruction loads.
5. out_valid=1 thread 2, flush_valid thread 2 -> out_valid=0 next edge; flush thread 1 instead -> entry retained.
6. in_exc=1 with src1 busy -> issues without stall, out_exc=1, no busy bit set; src=0 with in_use1 -> op1=0.

Source files
------------

// File: rtl/stage_id_mt.sv
// ---------------------------------------------------------------------------
// stage_id_mt -- decode/issue stage for the fine-grained multithreaded pipeline
//
// Sits between the IF/ID and ID/EX boundaries. Holds at most one decoded
// instruction in the ID/EX register.
//   - Reads operands from the per-thread register file.
//   - Keeps a per-thread scoreboard of outstanding register writes, with
//     same-cycle writeback bypass.
//   - Issues into EX through a valid/ready handshake.
//   - Supports a per-thread flush and counts stalled cycles.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           IF/ID handshake (in_ready is combinational)
//   in_thread, in_pc, in_exc      instruction thread, PC, fetch exception
//   in_src1/2, in_use1/2          source register ids and read enables
//   in_dst, in_wr                 destination id and write enable
//   in_imm, in_ctrl               immediate and opaque control bundle
//   rf_rd1/2_idx, rf_rd_thread    register file read address (combinational)
//   rf_rd1/2_data                 register file read data (combinational)
//   wb_valid, wb_we, wb_thread,   writeback / retire event
//   wb_dst, wb_data                 (clears scoreboard, feeds bypass)
//   flush_valid, flush_thread     kill younger instructions of one thread
//   out_valid / out_ready         ID/EX handshake
//   out_*                         registered instruction fields and operands
//   stall_cnt                     saturating count of in_valid & !in_ready
// ---------------------------------------------------------------------------
module stage_id_mt #(
  parameter int N_THREADS = 4,
  parameter int XLEN      = 32,
  parameter int N_REGS    = 32,
  parameter int CTRL_W    = 48,
  parameter int CNT_W     = 16,
  parameter int TID_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1,
  parameter int RID_W     = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TID_W-1:0]  in_thread,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_exc,
  input  logic [RID_W-1:0]  in_src1,
  input  logic [RID_W-1:0]  in_src2,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [RID_W-1:0]  in_dst,
  input  logic              in_wr,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [RID_W-1:0]  rf_rd1_idx,
  output logic [RID_W-1:0]  rf_rd2_idx,
  output logic [TID_W-1:0]  rf_rd_thread,
  input  logic [XLEN-1:0]   rf_rd1_data,
  input  logic [XLEN-1:0]   rf_rd2_data,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [TID_W-1:0]  wb_thread,
  input  logic [RID_W-1:0]  wb_dst,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush_valid,
  input  logic [TID_W-1:0]  flush_thread,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TID_W-1:0]  out_thread,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_exc,
  output logic [RID_W-1:0]  out_dst,
  output logic              out_wr,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [RID_W-1:0] REG_ZERO = {RID_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Operand select for one source: r0 reads zero, a same-cycle architectural
  // writeback to the same thread/register wins over the (stale) regfile data.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [RID_W-1:0] src,
    input logic [XLEN-1:0]  rf_data,
    input logic             byp_hit,
    input logic [XLEN-1:0]  byp_data
  );
    logic [XLEN-1:0] res;
    if (src == REG_ZERO) begin
      res = {XLEN{1'b0}};
    end else if (byp_hit) begin
      res = byp_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  logic [N_THREADS-1:0][N_REGS-1:0] busy_r;
  logic [N_THREADS-1:0][N_REGS-1:0] busy_nxt_s;

  logic            wb_hit1_s, wb_hit2_s;
  logic            byp1_s, byp2_s;
  logic            ebusy1_s, ebusy2_s;
  logic            hazard_s;
  logic            issue_ok_s;
  logic            flush_in_s;
  logic            flush_out_s;
  logic            accept_s;
  logic            sb_set_s;
  logic [XLEN-1:0] op1_s, op2_s;

  assign rf_rd1_idx   = in_src1;
  assign rf_rd2_idx   = in_src2;
  assign rf_rd_thread = in_thread;

  // Hazard detection, handshake and operand selection for the incoming instruction.
  always_comb begin
    wb_hit1_s = wb_valid & (wb_thread == in_thread) & (wb_dst == in_src1);
    wb_hit2_s = wb_valid & (wb_thread == in_thread) & (wb_dst == in_src2);
    // Bypass only architecturally valid data; a killed writeback still clears busy.
    byp1_s    = wb_hit1_s & wb_we;
    byp2_s    = wb_hit2_s & wb_we;
    ebusy1_s  = busy_r[in_thread][in_src1] & ~wb_hit1_s;
    ebusy2_s  = busy_r[in_thread][in_src2] & ~wb_hit2_s;

    if (in_valid && !in_exc) begin
      hazard_s = (in_use1 & (in_src1 != REG_ZERO) & ebusy1_s) |
                 (in_use2 & (in_src2 != REG_ZERO) & ebusy2_s);
    end else begin
      hazard_s = 1'b0;
    end

    issue_ok_s  = ~out_valid | out_ready;
    flush_in_s  = flush_valid & (flush_thread == in_thread);
    flush_out_s = flush_valid & out_valid & (out_thread == flush_thread);
    in_ready    = issue_ok_s & ~hazard_s & ~flush_in_s;
    accept_s    = in_valid & in_ready;
    sb_set_s    = accept_s & in_wr & ~in_exc & (in_dst != REG_ZERO);

    op1_s = sel_operand(in_src1, rf_rd1_data, byp1_s, wb_data);
    op2_s = sel_operand(in_src2, rf_rd2_data, byp2_s, wb_data);
  end

  // Scoreboard next state: clear on writeback, then set on issue so set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int t = 0; t < N_THREADS; t++) begin
      for (int r = 0; r < N_REGS; r++) begin
        busy_nxt_s[t][r] =
          (busy_r[t][r] & ~(wb_valid & (wb_thread == TID_W'(t)) & (wb_dst == RID_W'(r)))) |
          (sb_set_s & (in_thread == TID_W'(t)) & (in_dst == RID_W'(r)));
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {(N_THREADS*N_REGS){1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // ID/EX register: load on accept, drop on flush or consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_thread <= {TID_W{1'b0}};
      out_pc     <= {XLEN{1'b0}};
      out_exc    <= 1'b0;
      out_dst    <= {RID_W{1'b0}};
      out_wr     <= 1'b0;
      out_imm    <= {XLEN{1'b0}};
      out_ctrl   <= {CTRL_W{1'b0}};
      out_op1    <= {XLEN{1'b0}};
      out_op2    <= {XLEN{1'b0}};
    end else if (accept_s) begin
      // Accept implies the held entry is leaving (or absent), so it is simply replaced.
      out_valid  <= 1'b1;
      out_thread <= in_thread;
      out_pc     <= in_pc;
      out_exc    <= in_exc;
      out_dst    <= in_dst;
      out_wr     <= in_wr;
      out_imm    <= in_imm;
      out_ctrl   <= in_ctrl;
      out_op1    <= op1_s;
      out_op2    <= op2_s;
    end else if (flush_out_s || out_ready) begin
      // Data fields are left as-is; only the valid bit matters once dropped.
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating count of cycles where an offered instruction is not accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (in_valid && !in_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_stage_id_mt.sv
// ---------------------------------------------------------------------------
// tb_stage_id_mt -- table-driven self-checking bench for stage_id_mt.
// Each vector is one clock: inputs are driven, in_ready is checked before the
// edge, and the registered outputs plus stall_cnt are checked after it.
// The register file is a small combinational model: rf(t,r) = 0x1000*t + 0x11*(r-2).
// stall_cnt is instantiated 4 bits wide so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_stage_id_mt;

  localparam int TID_W  = 2;
  localparam int RID_W  = 5;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 48;
  localparam int CNT_W  = 4;

  typedef struct {
    int vld, thr, s1, u1, s2, u2, dst, wr, exc, ordy;
    int wbv, wbwe, wbt, wbd, wbdata, fv, ft, pc;
    int e_rdy, e_ov, e_chkop, e_op1, e_op2, e_exc, e_thr, e_dst, e_wr, e_pc, e_stall;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [TID_W-1:0]  in_thread;
  logic [XLEN-1:0]   in_pc;
  logic              in_exc;
  logic [RID_W-1:0]  in_src1, in_src2;
  logic              in_use1, in_use2;
  logic [RID_W-1:0]  in_dst;
  logic              in_wr;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RID_W-1:0]  rf_rd1_idx, rf_rd2_idx;
  logic [TID_W-1:0]  rf_rd_thread;
  logic [XLEN-1:0]   rf_rd1_data, rf_rd2_data;
  logic              wb_valid, wb_we;
  logic [TID_W-1:0]  wb_thread;
  logic [RID_W-1:0]  wb_dst;
  logic [XLEN-1:0]   wb_data;
  logic              flush_valid;
  logic [TID_W-1:0]  flush_thread;
  logic              out_valid, out_ready;
  logic [TID_W-1:0]  out_thread;
  logic [XLEN-1:0]   out_pc;
  logic              out_exc;
  logic [RID_W-1:0]  out_dst;
  logic              out_wr;
  logic [XLEN-1:0]   out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_op1, out_op2;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  stage_id_mt #(
    .N_THREADS(4), .XLEN(XLEN), .N_REGS(32), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_thread(in_thread), .in_pc(in_pc),
    .in_exc(in_exc), .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1),
    .in_use2(in_use2), .in_dst(in_dst), .in_wr(in_wr), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_rd1_idx(rf_rd1_idx), .rf_rd2_idx(rf_rd2_idx), .rf_rd_thread(rf_rd_thread),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_thread(wb_thread), .wb_dst(wb_dst),
    .wb_data(wb_data), .flush_valid(flush_valid), .flush_thread(flush_thread),
    .out_valid(out_valid), .out_ready(out_ready), .out_thread(out_thread),
    .out_pc(out_pc), .out_exc(out_exc), .out_dst(out_dst), .out_wr(out_wr),
    .out_imm(out_imm), .out_ctrl(out_ctrl), .out_op1(out_op1), .out_op2(out_op2),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model.
  function automatic logic [31:0] rf_val(input logic [1:0] t, input logic [4:0] r);
    return (32'h1000 * {30'd0, t}) + (32'h11 * ({27'd0, r} - 32'd2));
  endfunction

  assign rf_rd1_data = rf_val(rf_rd_thread, rf_rd1_idx);
  assign rf_rd2_data = rf_val(rf_rd_thread, rf_rd2_idx);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid     = (v.vld != 0);
    in_thread    = TID_W'(v.thr);
    in_src1      = RID_W'(v.s1);
    in_use1      = (v.u1 != 0);
    in_src2      = RID_W'(v.s2);
    in_use2      = (v.u2 != 0);
    in_dst       = RID_W'(v.dst);
    in_wr        = (v.wr != 0);
    in_exc       = (v.exc != 0);
    out_ready    = (v.ordy != 0);
    wb_valid     = (v.wbv != 0);
    wb_we        = (v.wbwe != 0);
    wb_thread    = TID_W'(v.wbt);
    wb_dst       = RID_W'(v.wbd);
    wb_data      = XLEN'(v.wbdata);
    flush_valid  = (v.fv != 0);
    flush_thread = TID_W'(v.ft);
    in_pc        = XLEN'(v.pc);
    in_imm       = XLEN'(v.pc) ^ 32'hFFFF_0000;
    in_ctrl      = {16'h5A5A, XLEN'(v.pc)};
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] epc;
    epc = XLEN'(v.e_pc);
    drive(v);
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'(v.e_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 64'(out_valid), 64'(v.e_ov));
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(v.e_stall));
    if (v.e_ov != 0) begin
      chk({tag, " out_thread"}, 64'(out_thread), 64'(v.e_thr));
      chk({tag, " out_dst"}, 64'(out_dst), 64'(v.e_dst));
      chk({tag, " out_wr"}, 64'(out_wr), 64'(v.e_wr));
      chk({tag, " out_exc"}, 64'(out_exc), 64'(v.e_exc));
      chk({tag, " out_pc"}, 64'(out_pc), 64'(epc));
      chk({tag, " out_imm"}, 64'(out_imm), 64'(epc ^ 32'hFFFF_0000));
      chk({tag, " out_ctrl"}, 64'(out_ctrl), 64'({16'h5A5A, epc}));
      if (v.e_chkop != 0) begin
        chk({tag, " out_op1"}, 64'(out_op1), 64'(unsigned'(v.e_op1)));
        chk({tag, " out_op2"}, 64'(out_op2), 64'(unsigned'(v.e_op2)));
      end
    end
  endtask

  vec_t tbl[20];
  vec_t seqa[3];
  vec_t v;

  initial begin
    //            vld thr s1 u1 s2 u2 dst wr exc ordy wbv we wbt wbd wbdata   fv ft pc      | rdy ov chk op1     op2     exc thr dst wr pc      stall
    // basic issue, scoreboard sets busy[0][5]
    tbl[0]  = '{1, 0,  3, 1, 4, 1, 5,  1, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h100,  1, 1, 1, 32'h11,   32'h22,   0, 0, 5, 1, 32'h100, 0};
    // RAW on r5: stall twice, then same-cycle writeback bypass
    tbl[1]  = '{1, 0,  5, 1, 3, 1, 6,  1, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h104,  0, 0, 0, 0,        0,        0, 0, 0, 0, 0,       1};
    tbl[2]  = '{1, 0,  5, 1, 3, 1, 6,  1, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h104,  0, 0, 0, 0,        0,        0, 0, 0, 0, 0,       2};
    tbl[3]  = '{1, 0,  5, 1, 3, 1, 6,  1, 0, 1,  1, 1, 0, 5, 32'hABCD, 0, 0, 32'h104, 1, 1, 1, 32'hABCD, 32'h11,   0, 0, 6, 1, 32'h104, 2};
    // thread 0 writes r5 again; thread 1 reading r5/r6 is not blocked
    tbl[4]  = '{1, 0,  0, 0, 0, 0, 5,  1, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h108,  1, 1, 1, 0,        0,        0, 0, 5, 1, 32'h108, 2};
    tbl[5]  = '{1, 1,  5, 1, 6, 1, 7,  1, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h10C,  1, 1, 1, 32'h1033, 32'h1044, 0, 1, 7, 1, 32'h10C, 2};
    // thread 0 reading busy r6 on src2 stalls
    tbl[6]  = '{1, 0,  3, 1, 6, 1, 0,  0, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h110,  0, 0, 0, 0,        0,        0, 0, 0, 0, 0,       3};
    // backpressure: load, hold 3 cycles, then release
    tbl[7]  = '{1, 2,  3, 1, 4, 1, 8,  1, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h114,  1, 1, 1, 32'h2011, 32'h2022, 0, 2, 8, 1, 32'h114, 3};
    tbl[8]  = '{1, 3,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0,       0, 0, 32'h118,  0, 1, 1, 32'h2011, 32'h2022, 0, 2, 8, 1, 32'h114, 4};
    tbl[9]  = '{1, 3,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0,       0, 0, 32'h118,  0, 1, 1, 32'h2011, 32'h2022, 0, 2, 8, 1, 32'h114, 5};
    tbl[10] = '{1, 3,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0,       0, 0, 32'h118,  0, 1, 1, 32'h2011, 32'h2022, 0, 2, 8, 1, 32'h114, 6};
    tbl[11] = '{1, 3,  0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h118,  1, 1, 1, 0,        0,        0, 3, 0, 0, 32'h118, 6};
    // flush of the held thread drops it; flush of another thread keeps it
    tbl[12] = '{1, 2,  0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h11C,  1, 1, 1, 0,        0,        0, 2, 0, 0, 32'h11C, 6};
    tbl[13] = '{0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0,       1, 2, 0,        0, 0, 0, 0,        0,        0, 0, 0, 0, 0,       6};
    tbl[14] = '{1, 2,  0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h120,  1, 1, 1, 0,        0,        0, 2, 0, 0, 32'h120, 6};
    tbl[15] = '{0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0,       1, 1, 0,        0, 1, 1, 0,        0,        0, 2, 0, 0, 32'h120, 6};
    // incoming instruction of the flushed thread is refused
    tbl[16] = '{1, 1,  0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0,       1, 1, 32'h124,  0, 0, 0, 0,        0,        0, 0, 0, 0, 0,       7};
    // exception bypasses hazard on busy r6, sets no busy on r9
    tbl[17] = '{1, 0,  6, 1, 5, 1, 9,  1, 1, 1,  0, 0, 0, 0, 0,       0, 0, 32'h128,  1, 1, 0, 0,        0,        1, 0, 9, 1, 32'h128, 7};
    // r9 free; src1 = r0 with use reads zero
    tbl[18] = '{1, 0,  0, 1, 9, 1, 0,  0, 0, 1,  0, 0, 0, 0, 0,       0, 0, 32'h12C,  1, 1, 1, 0,        32'h77,   0, 0, 0, 0, 32'h12C, 7};
    // killed writeback clears busy r6 but does not bypass its data
    tbl[19] = '{1, 0,  6, 1, 0, 0, 0,  0, 0, 1,  1, 0, 0, 6, 32'hDEAD, 0, 0, 32'h130, 1, 1, 1, 32'h44,   0,        0, 0, 0, 0, 32'h130, 7};

    // set and clear of the same entry in one cycle: set wins
    seqa[0] = '{1, 0,  0, 0, 0, 0, 10, 1, 0, 1,  1, 1, 0, 10, 32'h5555, 0, 0, 32'h140, 1, 1, 1, 0,       0,        0, 0, 10, 1, 32'h140, 7};
    seqa[1] = '{1, 0, 10, 1, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0,  0,        0, 0, 32'h144, 0, 0, 0, 0,       0,        0, 0, 0,  0, 0,       8};
    seqa[2] = '{1, 0, 10, 1, 0, 0, 0,  0, 0, 1,  1, 1, 0, 10, 32'h5555, 0, 0, 32'h144, 1, 1, 1, 32'h5555, 0,       0, 0, 0,  0, 32'h144, 8};

    // Reset state
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(v);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_pc", 64'(out_pc), 64'd0);
    chk("reset out_op1", 64'(out_op1), 64'd0);
    chk("reset out_op2", 64'(out_op2), 64'd0);
    chk("reset out_ctrl", 64'(out_ctrl), 64'd0);
    chk("reset out_exc", 64'(out_exc), 64'd0);
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      run_vec(seqa[i], $sformatf("setwins%0d", i));
    end

    // Stall counter saturation while thread 0 waits on busy r5
    for (int k = 0; k < 10; k++) begin
      v = '{1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h148,
            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ((9 + k) > 15) ? 15 : (9 + k)};
      run_vec(v, $sformatf("sat%0d", k));
    end

    // Reset while holding an instruction discards it and clears the scoreboard
    v = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h200,
          1, 1, 1, 0, 0, 0, 2, 0, 0, 32'h200, 15};
    run_vec(v, "preflush");
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(v);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst out_pc", 64'(out_pc), 64'd0);
    chk("midrst out_thread", 64'(out_thread), 64'd0);
    chk("midrst stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    v = '{1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h204,
          1, 1, 1, 32'h33, 0, 0, 0, 0, 0, 32'h204, 0};
    run_vec(v, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
